pc_sequencer: RTL

//  Registered, parametrised program-counter unit for the fetch stage. Holds the PC, computes the

---
 rtl/pc_pkg.sv | 48 ++++
 rtl/pc_ras.sv | 58 +++++
 rtl/pc_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter unit: pc_sel codes,
// sequencer FSM states and the next-PC computation.
// Optional return-address stack is enabled by defining PC_RAS_EN.
package pc_pkg;

  // Widest PC the next-PC helper supports; callers zero-extend into this width.
  localparam int PC_MAX_W = 64;

  typedef enum logic [1:0] {
    PC_SEL_JUMP = 2'b00,
    PC_SEL_SEQ  = 2'b01,
    PC_SEL_JREG = 2'b10,
    PC_SEL_TRAP = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } pc_state_e;

  // Redirect target at full helper width; the caller keeps the low ADDR_W bits,
  // which makes every case wrap modulo 2^ADDR_W.
  function automatic logic [PC_MAX_W-1:0] next_pc(
    input pc_sel_e               sel,
    input logic [PC_MAX_W-1:0]   pc_plus4,
    input logic                  taken,
    input logic [15:0]           imm,
    input logic [25:0]           addr,
    input logic [PC_MAX_W-1:0]   da,
    input logic [PC_MAX_W-1:0]   trap_pc
  );
    logic [PC_MAX_W-1:0] offset;
    logic [PC_MAX_W-1:0] result;
    // Word offset, sign-extended and scaled to bytes.
    offset = taken ? {{(PC_MAX_W-18){imm[15]}}, imm, 2'b00} : '0;
    unique case (sel)
      // Region bits above 28 come from pc_plus4; the low 28 from the jump field.
      PC_SEL_JUMP: result = (pc_plus4 & ~{{(PC_MAX_W-28){1'b0}}, 28'hFFF_FFFF})
                          | {{(PC_MAX_W-28){1'b0}}, addr, 2'b00};
      PC_SEL_JREG: result = da;
      PC_SEL_TRAP: result = trap_pc;
      default:     result = pc_plus4 + offset;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// a pop when empty is ignored. top reads 0 while the stack is empty.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign top   = empty ? '0 : mem_q[ptr_q];

  // Pointer/occupancy update; the pointer wraps because DEPTH is a power of 2.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      cnt_d = full ? cnt_q : cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Occupancy state; clearing the count is what empties the stack on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage.
  // NOTE: the array has no reset; stale entries are unreachable because top is gated by empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_d] <= data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: holds the PC, computes the next PC and offers it to
// instruction memory with a valid/ready handshake. Redirects that cannot be taken
// immediately are held in a pending register (newest wins) until the next fire.
// Define PC_RAS_EN to add the return-address stack prediction on ras_top.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] TRAP_PC  = 'h80,
  parameter int              RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              halt,
  input  logic [1:0]        pc_sel,
  input  logic              redirect,
  input  logic              branch,
  input  logic              br_ne,
  input  logic              is_zero,
  input  logic [15:0]       imm,
  input  logic [25:0]       addr,
  input  logic [ADDR_W-1:0] da,
  input  logic              is_call,
  input  logic              is_ret,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] ras_top,
  output logic              halted
);

  if (ADDR_W < 28 || ADDR_W > PC_MAX_W) begin : g_bad_addr_w
    $error("pc_sequencer: ADDR_W must be in 28..%0d", PC_MAX_W);
  end

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              halted_q, halted_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_push_q, pend_push_d;
  logic              pend_pop_q, pend_pop_d;

  pc_sel_e             sel;
  logic                fire;
  logic                taken;
  logic                redir_push, redir_pop;
  logic                fire_push, fire_pop;
  logic [PC_MAX_W-1:0] plus4_ext, da_ext, trap_ext, target_ext;
  logic [ADDR_W-1:0]   redir_pc;
  logic                unused_ok;

  assign sel      = pc_sel_e'(pc_sel);
  assign pc_out   = pc_q;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign fire     = pc_valid_q & if_ready & ~stall;
  assign taken    = branch & (is_zero ^ br_ne);

  assign redir_push = (sel == PC_SEL_JUMP) & is_call;
  assign redir_pop  = (sel == PC_SEL_JREG) & is_ret;

  // Redirect target from the current operands, widened for the shared helper.
  always_comb begin
    plus4_ext = '0;
    da_ext    = '0;
    trap_ext  = '0;
    plus4_ext[ADDR_W-1:0] = pc_plus4;
    da_ext[ADDR_W-1:0]    = da;
    trap_ext[ADDR_W-1:0]  = TRAP_PC;
    target_ext = next_pc(sel, plus4_ext, taken, imm, addr, da_ext, trap_ext);
    redir_pc   = target_ext[ADDR_W-1:0];
  end

  // Next-state logic: FSM, PC step, pending redirect and RAS push/pop requests.
  always_comb begin
    // NOTE: every output gets a hold value first so no path through the case infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    halted_d     = halted_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    pend_push_d  = pend_push_q;
    pend_pop_d   = pend_pop_q;
    fire_push    = 1'b0;
    fire_pop     = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        state_d    = ST_RUN;
        pc_valid_d = 1'b1;
        if (redirect) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redir_pc;
          pend_push_d  = redir_push;
          pend_pop_d   = redir_pop;
        end
      end

      ST_RUN: begin
        if (fire) begin
          // A same-cycle redirect bypasses (and discards) anything pending.
          if (redirect) begin
            pc_d      = redir_pc;
            fire_push = redir_push;
            fire_pop  = redir_pop;
          end else if (pend_valid_q) begin
            pc_d      = pend_pc_q;
            fire_push = pend_push_q;
            fire_pop  = pend_pop_q;
          end else begin
            pc_d = pc_plus4;
          end
          pend_valid_d = 1'b0;
          pend_push_d  = 1'b0;
          pend_pop_d   = 1'b0;
          if (halt) begin
            state_d    = ST_HALT;
            pc_valid_d = 1'b0;
            halted_d   = 1'b1;
          end
        end else if (redirect) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redir_pc;
          pend_push_d  = redir_push;
          pend_pop_d   = redir_pop;
        end
      end

      ST_HALT: begin
        // Only a trap wakes the sequencer; it restarts fetch at the trap vector.
        if (redirect && sel == PC_SEL_TRAP && !stall) begin
          state_d    = ST_RUN;
          pc_d       = TRAP_PC;
          pc_valid_d = 1'b1;
          halted_d   = 1'b0;
        end
      end

      default: begin
        state_d    = ST_BOOT;
        pc_valid_d = 1'b0;
        halted_d   = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
    if (!reset_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      pc_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      pend_push_q  <= 1'b0;
      pend_pop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      halted_q     <= halted_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      pend_push_q  <= pend_push_d;
      pend_pop_q   <= pend_pop_d;
    end
  end

`ifdef PC_RAS_EN
  logic ras_empty, ras_full;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fire_push),
    .pop     (fire_pop),
    .data    (pc_plus4),
    .top     (ras_top),
    .empty   (ras_empty),
    .full    (ras_full)
  );

  assign unused_ok = ^{target_ext, ras_empty, ras_full};
`else
  assign ras_top   = '0;
  assign unused_ok = ^{target_ext, fire_push, fire_pop, RAS_DEPTH[0]};
`endif

endmodule
